// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Collects completed results from NUM_FU functional units into one-entry
//   holding buffers. Each cycle it grants up to four occupied buffers in
//   round-robin order and broadcasts them on four registered CDB lanes.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   flush               synchronous discard of buffered and in-flight results
//   fu_valid[i]         FU i presents a result
//   fu_rob_index[i]     destination ROB slot of that result
//   fu_result[i]        result value
//   fu_ready[i]         buffer i accepts a result at the next edge
//   cdb_valid[l]        lane l carries a result this cycle
//   cdb_rob_index[l]    lane l ROB index (0 when lane idle)
//   cdb_result[l]       lane l value (0 when lane idle)
//
// Build option
//   CDB_ARB_FIXED_PRIO_EN  when defined, the round-robin pointer is removed
//                          and the scan always starts at FU 0.

module cdb_arbiter #(
  parameter int NUM_FU    = 6,
  parameter int ROB_IDX_W = 4,
  parameter int DATA_W    = 16,
  localparam int PTR_W    = $clog2(NUM_FU)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 fu_valid      [NUM_FU],
  input  logic [ROB_IDX_W-1:0] fu_rob_index  [NUM_FU],
  input  logic [DATA_W-1:0]    fu_result     [NUM_FU],
  output logic                 fu_ready      [NUM_FU],
  output logic                 cdb_valid     [4],
  output logic [ROB_IDX_W-1:0] cdb_rob_index [4],
  output logic [DATA_W-1:0]    cdb_result    [4]
);

  logic [NUM_FU-1:0]    occ_q, occ_d;
  logic [ROB_IDX_W-1:0] rob_q [NUM_FU];
  logic [ROB_IDX_W-1:0] rob_d [NUM_FU];
  logic [DATA_W-1:0]    data_q [NUM_FU];
  logic [DATA_W-1:0]    data_d [NUM_FU];

  logic [3:0]           cdb_valid_q, cdb_valid_d;
  logic [ROB_IDX_W-1:0] cdb_rob_q [4];
  logic [ROB_IDX_W-1:0] cdb_rob_d [4];
  logic [DATA_W-1:0]    cdb_res_q [4];
  logic [DATA_W-1:0]    cdb_res_d [4];

  logic [NUM_FU-1:0]    grant;
  logic [NUM_FU-1:0]    ready;
  logic [3:0]           lane_vld;
  logic [PTR_W-1:0]     lane_sel [4];
  logic [PTR_W-1:0]     scan_base;

`ifdef CDB_ARB_FIXED_PRIO_EN
  assign scan_base = '0;
`else
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     last_idx;
  logic                 any_grant;
  logic [PTR_W:0]       ptr_inc;

  assign scan_base = rr_ptr_q;
`endif

  // Scan from scan_base with wrap; the first four occupied buffers get lanes
  // in scan order.
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic [2:0]       cnt;
    grant    = '0;
    lane_vld = '0;
    for (int l = 0; l < 4; l++) lane_sel[l] = '0;
    sum = '0;
    idx = '0;
    cnt = '0;
`ifndef CDB_ARB_FIXED_PRIO_EN
    last_idx  = '0;
    any_grant = 1'b0;
`endif
    for (int k = 0; k < NUM_FU; k++) begin
      sum = {1'b0, scan_base} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_FU)) sum = sum - (PTR_W+1)'(NUM_FU);
      idx = sum[PTR_W-1:0];
      if (occ_q[idx] && (cnt < 3'd4)) begin
        grant[idx]             = 1'b1;
        lane_vld[cnt[1:0]]     = 1'b1;
        lane_sel[cnt[1:0]]     = idx;
        cnt                    = cnt + 3'd1;
`ifndef CDB_ARB_FIXED_PRIO_EN
        last_idx               = idx;
        any_grant              = 1'b1;
`endif
      end
    end
  end

  // A granted buffer drains this cycle, so it may reload at the same edge.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      ready[i] = ~flush & (~occ_q[i] | grant[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      occ_d[i]  = occ_q[i] & ~grant[i];
      rob_d[i]  = rob_q[i];
      data_d[i] = data_q[i];
      if (fu_valid[i] && ready[i]) begin
        occ_d[i]  = 1'b1;
        rob_d[i]  = fu_rob_index[i];
        data_d[i] = fu_result[i];
      end
      if (flush) occ_d[i] = 1'b0;
    end
    for (int l = 0; l < 4; l++) begin
      cdb_valid_d[l] = lane_vld[l] & ~flush;
      cdb_rob_d[l]   = cdb_valid_d[l] ? rob_q[lane_sel[l]]  : '0;
      cdb_res_d[l]   = cdb_valid_d[l] ? data_q[lane_sel[l]] : '0;
    end
  end

`ifndef CDB_ARB_FIXED_PRIO_EN
  always_comb begin
    ptr_inc  = {1'b0, last_idx} + (PTR_W+1)'(1);
    if (ptr_inc >= (PTR_W+1)'(NUM_FU)) ptr_inc = '0;
    rr_ptr_d = rr_ptr_q;
    if (any_grant && !flush) rr_ptr_d = ptr_inc[PTR_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q       <= '0;
      cdb_valid_q <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        rob_q[i]  <= '0;
        data_q[i] <= '0;
      end
      for (int l = 0; l < 4; l++) begin
        cdb_rob_q[l] <= '0;
        cdb_res_q[l] <= '0;
      end
    end else begin
      occ_q       <= occ_d;
      cdb_valid_q <= cdb_valid_d;
      for (int i = 0; i < NUM_FU; i++) begin
        rob_q[i]  <= rob_d[i];
        data_q[i] <= data_d[i];
      end
      for (int l = 0; l < 4; l++) begin
        cdb_rob_q[l] <= cdb_rob_d[l];
        cdb_res_q[l] <= cdb_res_d[l];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) fu_ready[i] = ready[i];
    for (int l = 0; l < 4; l++) begin
      cdb_valid[l]     = cdb_valid_q[l];
      cdb_rob_index[l] = cdb_rob_q[l];
      cdb_result[l]    = cdb_res_q[l];
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  localparam int NF = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        fu_valid      [NF];
  logic [3:0]  fu_rob_index  [NF];
  logic [15:0] fu_result     [NF];
  logic        fu_ready      [NF];
  logic        cdb_valid     [4];
  logic [3:0]  cdb_rob_index [4];
  logic [15:0] cdb_result    [4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_FU(NF), .ROB_IDX_W(4), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_valid(fu_valid), .fu_rob_index(fu_rob_index), .fu_result(fu_result),
    .fu_ready(fu_ready),
    .cdb_valid(cdb_valid), .cdb_rob_index(cdb_rob_index), .cdb_result(cdb_result)
  );

  typedef struct packed {
    logic [5:0]      valid;
    logic [7:0]      tag;
    logic [5:0]      exp_ready;
    logic [3:0]      exp_vld;
    logic [3:0][2:0] exp_fu;
    logic [7:0]      exp_tag;
  } vec_t;

  typedef struct packed {
    logic [3:0]       vld;
    logic [3:0][3:0]  rob;
    logic [3:0][15:0] res;
  } lanes_t;

  vec_t   vecs [16];
  lanes_t exp_q [$];

  function automatic logic [3:0] rob_of(input int i, input logic [7:0] t);
    return 4'(t[3:0] + 4'(i));
  endfunction

  function automatic logic [15:0] res_of(input int i, input logic [7:0] t);
    return {t, 8'(i)};
  endfunction

  function automatic vec_t mk(input logic [5:0] v, input logic [7:0] t,
                              input logic [5:0] r, input logic [3:0] ev,
                              input logic [11:0] ef, input logic [7:0] et);
    vec_t x;
    x.valid = v; x.tag = t; x.exp_ready = r;
    x.exp_vld = ev; x.exp_fu = ef; x.exp_tag = et;
    return x;
  endfunction

  function automatic lanes_t lanes_of(input vec_t v);
    lanes_t e;
    e = '0;
    for (int l = 0; l < 4; l++) begin
      e.vld[l] = v.exp_vld[l];
      if (v.exp_vld[l]) begin
        e.rob[l] = rob_of(int'(v.exp_fu[l]), v.exp_tag);
        e.res[l] = res_of(int'(v.exp_fu[l]), v.exp_tag);
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [5:0] v, input logic [7:0] t);
    for (int i = 0; i < NF; i++) begin
      fu_valid[i]     = v[i];
      fu_rob_index[i] = rob_of(i, t);
      fu_result[i]    = res_of(i, t);
    end
  endtask

  function automatic logic [5:0] ready_vec();
    logic [5:0] r;
    for (int i = 0; i < NF; i++) r[i] = fu_ready[i];
    return r;
  endfunction

  task automatic chk_lanes(input string name, input lanes_t e);
    for (int l = 0; l < 4; l++) begin
      chk($sformatf("%s_vld%0d", name, l), 32'(cdb_valid[l]), 32'(e.vld[l]));
      chk($sformatf("%s_dat%0d", name, l), {12'd0, cdb_rob_index[l], cdb_result[l]},
          {12'd0, e.rob[l], e.res[l]});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; drive(6'h00, 8'h00);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    lanes_t e;
    int     cnt [NF];

    vecs[0]  = mk(6'h3F, 8'h11, 6'h3F, 4'b0000, 12'h000, 8'h00);
    vecs[1]  = mk(6'h00, 8'h00, 6'h0F, 4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 8'h11);
    vecs[2]  = mk(6'h00, 8'h00, 6'h3F, 4'b0011, {3'd0, 3'd0, 3'd5, 3'd4}, 8'h11);
    vecs[3]  = mk(6'h00, 8'h00, 6'h3F, 4'b0000, 12'h000, 8'h00);
    vecs[4]  = mk(6'h04, 8'h22, 6'h3F, 4'b0000, 12'h000, 8'h00);
    vecs[5]  = mk(6'h00, 8'h00, 6'h3F, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd2}, 8'h22);
    vecs[6]  = mk(6'h00, 8'h00, 6'h3F, 4'b0000, 12'h000, 8'h00);
    vecs[7]  = mk(6'h02, 8'h31, 6'h3F, 4'b0000, 12'h000, 8'h00);
    vecs[8]  = mk(6'h02, 8'h32, 6'h3F, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd1}, 8'h31);
    vecs[9]  = mk(6'h02, 8'h33, 6'h3F, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd1}, 8'h32);
    vecs[10] = mk(6'h02, 8'h34, 6'h3F, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd1}, 8'h33);
    vecs[11] = mk(6'h00, 8'h00, 6'h3F, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd1}, 8'h34);
    vecs[12] = mk(6'h00, 8'h00, 6'h3F, 4'b0000, 12'h000, 8'h00);
    vecs[13] = mk(6'h23, 8'h41, 6'h3F, 4'b0000, 12'h000, 8'h00);
`ifdef CDB_ARB_FIXED_PRIO_EN
    vecs[14] = mk(6'h00, 8'h00, 6'h3F, 4'b0111, {3'd0, 3'd5, 3'd1, 3'd0}, 8'h41);
`else
    vecs[14] = mk(6'h00, 8'h00, 6'h3F, 4'b0111, {3'd0, 3'd1, 3'd0, 3'd5}, 8'h41);
`endif
    vecs[15] = mk(6'h00, 8'h00, 6'h3F, 4'b0000, 12'h000, 8'h00);

    rst = 1'b1; flush = 1'b0; drive(6'h00, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_lanes("reset_state", '0);
    chk("reset_ready", 32'(ready_vec()), 32'h3F);
    rst = 1'b0;

    // table: overload, single result, streaming, wrap-around
    for (int v = 0; v < 16; v++) begin
      @(negedge clk);
      drive(vecs[v].valid, vecs[v].tag);
      exp_q.push_back(lanes_of(vecs[v]));
      #1;
      chk($sformatf("ready_v%0d", v), 32'(ready_vec()), 32'(vecs[v].exp_ready));
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk_lanes($sformatf("lanes_v%0d", v), e);
      end
    end

    // async reset mid-cycle with buffers 0 and 3 occupied and lanes busy
    @(negedge clk); drive(6'h09, 8'h51);
    @(negedge clk);
    @(posedge clk); #1;
`ifdef CDB_ARB_FIXED_PRIO_EN
    chk_lanes("pre_rst", lanes_of(mk(6'h00, 8'h00, 6'h3F, 4'b0011, {3'd0, 3'd0, 3'd3, 3'd0}, 8'h51)));
`else
    chk_lanes("pre_rst", lanes_of(mk(6'h00, 8'h00, 6'h3F, 4'b0011, {3'd0, 3'd0, 3'd0, 3'd3}, 8'h51)));
`endif
    #2;
    drive(6'h00, 8'h00);
    rst = 1'b1;
    #1;
    chk_lanes("rst_async", '0);
    chk("rst_async_ready", 32'(ready_vec()), 32'h3F);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1; chk_lanes("post_rst1", '0);
    @(posedge clk); #1; chk_lanes("post_rst2", '0);

    // flush with three buffers occupied and a new arrival offered
    @(negedge clk); drive(6'h16, 8'h61);
    @(negedge clk); drive(6'h01, 8'h62); flush = 1'b1;
    #1; chk("flush_ready", 32'(ready_vec()), 32'h00);
    @(posedge clk); #1; chk_lanes("flush_edge", '0);
    @(negedge clk); flush = 1'b0; drive(6'h00, 8'h00);
    #1; chk("post_flush_ready", 32'(ready_vec()), 32'h3F);
    @(posedge clk); #1; chk_lanes("post_flush1", '0);
    @(posedge clk); #1; chk_lanes("post_flush2", '0);

    // fairness: all FUs valid for six cycles, count grants over six grant edges
    do_reset();
    for (int i = 0; i < NF; i++) cnt[i] = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      drive((c < 6) ? 6'h3F : 6'h00, 8'(8'h70 + c));
      @(posedge clk); #1;
      if (c >= 1) begin
        for (int l = 0; l < 4; l++) begin
          if (cdb_valid[l] && (cdb_result[l][7:0] < 8'(NF))) cnt[cdb_result[l][7:0]]++;
        end
      end
    end
    for (int i = 0; i < NF; i++) begin
`ifdef CDB_ARB_FIXED_PRIO_EN
      chk($sformatf("grants_fu%0d", i), 32'(cnt[i]), (i < 4) ? 32'd6 : 32'd0);
`else
      chk($sformatf("grants_fu%0d", i), 32'(cnt[i]), 32'd4);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
